// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter sharing one 32-bit barrel shifter (SLL/SRL/SRA/PASS).
// Right shifts reuse the left shifter via bit reversal; result sits in a one-entry tagged register.
module shift_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_operand,
   input  logic [4:0]       req0_shamt,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_operand,
   input  logic [4:0]       req1_shamt,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_id,
   output logic [WIDTH-1:0] res_data
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;

   function automatic logic [WIDTH-1:0] rev(input logic [WIDTH-1:0] a);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) r[i] = a[WIDTH-1-i];
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] lshift(input logic [WIDTH-1:0] a, input logic [4:0] sh);
      return a << sh;
   endfunction

   function automatic logic [WIDTH-1:0] shift_result(input logic [1:0] op,
                                                     input logic signed [WIDTH-1:0] a,
                                                     input logic [4:0] sh);
      logic [WIDTH-1:0] srl;
      logic [WIDTH-1:0] fill;
      srl  = rev(lshift(rev(a), sh));
      // Ones in the vacated upper bits, used only for negative SRA operands
      fill = ~rev(lshift({WIDTH{1'b1}}, sh));
      case (op)
         OP_SLL:  return lshift(a, sh);
         OP_SRL:  return srl;
         OP_SRA:  return a[WIDTH-1] ? (srl | fill) : srl;
         default: return a;
      endcase
   endfunction

   logic                    prio;
   logic                    slot_free;
   logic                    gnt0;
   logic                    gnt1;
   logic                    grant;
   logic [1:0]              op_p0;
   logic signed [WIDTH-1:0] opd_p0;
   logic [4:0]              sh_p0;
   logic [WIDTH-1:0]        data_p1;
   logic                    id_p1;
   logic                    vld_p1;

   // Stage 0: arbitration and shift on the granted request
   always_comb begin
      slot_free = !vld_p1 | res_ready;
      gnt0      = slot_free & req0_valid & (!req1_valid | !prio);
      gnt1      = slot_free & req1_valid & (!req0_valid | prio);
      grant     = gnt0 | gnt1;
      op_p0     = gnt1 ? req1_op      : req0_op;
      opd_p0    = gnt1 ? req1_operand : req0_operand;
      sh_p0     = gnt1 ? req1_shamt   : req0_shamt;
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   // Stage 1: result register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_p1  <= 1'b0;
         id_p1   <= 1'b0;
         data_p1 <= '0;
         prio    <= 1'b0;
      end else if (grant) begin
         vld_p1  <= 1'b1;
         id_p1   <= gnt1;
         data_p1 <= shift_result(op_p0, opd_p0, sh_p0);
         prio    <= ~gnt1;
      end else if (res_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign res_valid = vld_p1;
   assign res_id    = id_p1;
   assign res_data  = data_p1;

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 32-bit barrel-shift datapath between two requesters: requester 0 is the ALU shift path, requester 1 is load/store byte-lane alignment.
- Round-robin arbitration on a valid/ready handshake.
- Supports SLL, SRL and SRA. The right shifts reuse the left-shift datapath through bit reversal.
- Result is held in a single-entry output register with a requester tag and a valid/ready handshake. Latency is one cycle.

Parameters:
- WIDTH, 32, data width. Fixed at 32: the shift datapath is 32-bit with a 5-bit amount.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous reset, active-high
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle (combinational grant)
- req0_op  in  2  00=SLL, 01=SRL, 10=SRA, 11=PASS
- req0_operand  in  32  value to shift
- req0_shamt  in  5  shift amount 0..31
- req1_valid, req1_ready, req1_op, req1_operand, req1_shamt: same as requester 0, for requester 1
- res_valid  out  1  result register holds a valid result
- res_ready  in  1  consumer takes the result this cycle
- res_id  out  1  requester that owns the result (0 or 1)
- res_data  out  32  shifted result

Behaviour:
- Reset values (asynchronous, active-high): res_valid=0, res_id=0, res_data=0, priority pointer prio=0 (requester 0 favoured). Any result in flight is dropped immediately; a mid-operation reset loses it. No output glitch beyond reset deassertion.
- slot_free = !res_valid | res_ready. No grant is issued when slot_free=0.
- Arbitration (combinational, when slot_free=1):
  - Only reqK_valid high: grant K.
  - Both valid: grant the requester selected by prio.
  - At most one reqK_ready is high per cycle.
  - reqK_ready never asserts unless reqK_valid is high.
- Pointer update: on a grant to K, prio <= 1-K on the clock edge. Without a grant, prio holds. Result: strict alternation under continuous contention, no starvation. Worst-case wait is one grant.
- Datapath input is muxed from the granted requester. Result:
  - SLL: operand << shamt, zero fill.
  - SRL: rev(lshift(rev(operand), shamt)), where rev is 32-bit bit reversal.
  - SRA: SRL result OR'd with fill mask ~rev(lshift(rev(32'hFFFFFFFF), shamt)), applied only when operand[31]=1.
  - PASS: operand unchanged; shamt ignored.
  - shamt=0 returns operand for every op.
- Capture: on a grant edge, res_data <= result, res_id <= K, res_valid <= 1. The result is visible the cycle after the grant (latency 1).
- Drain: res_valid && res_ready with no grant clears res_valid to 0 at the edge.
- Simultaneous drain and grant (res_valid=1, res_ready=1): the new result overwrites in the same edge and res_valid stays 1. Full throughput is one result per cycle.
- Backpressure: while res_valid=1 and res_ready=0:
  - res_data and res_id hold stable.
  - No grants are issued.
  - Requesters must hold op/operand/shamt stable while valid and not ready.
- Withdrawal: a requester may drop valid without a grant. No state changes.
- res_ready while res_valid=0 is ignored.

Test Plan:
- Reset then idle: after reset, res_valid=0, res_data=0, both readies 0 with no valid. Assert reset mid-backpressure -> res_valid falls to 0 immediately, prio=0.
- Single requester ops: req0 operand 32'h8000_00F1, shamt 4, res_ready=1. Required results, each one cycle after grant with res_id=0:
  - SLL -> 32'h0000_0F10
  - SRL -> 32'h0800_000F
  - SRA -> 32'hF800_000F
  - PASS -> 32'h8000_00F1
  - shamt 0 SRA -> 32'h8000_00F1
  - shamt 31 SRA -> 32'hFFFF_FFFF
- Contention: both valid continuously for 6 cycles, res_ready=1 -> grant sequence 0,1,0,1,0,1 and a res_id sequence matching it. One result per cycle, no idle cycles.
- Backpressure: res_ready=0 for 3 cycles with both valid -> no ready asserted, res_data/res_id stable. Raise res_ready -> drain and new grant on the same edge, res_valid stays 1.
- Pointer after lone grants: req1 alone granted, then both valid -> requester 0 granted next. req0 alone granted twice, then both valid -> requester 1 granted.
- Random soak, 10k cycles: both requesters random valid, ops random, random res_ready -> scoreboard matches a reference shift model in per-requester order. No request lost or duplicated; no consecutive-grant starvation over 2 grants.
